// File: rtl/key_event_pkg.sv
// Shared types and register addresses for the push-button event block.
package key_event_pkg;

  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} key_state_t;

  localparam logic [15:0] KEY_UP_ADDR   = 16'hc014;
  localparam logic [15:0] KEY_DOWN_ADDR = 16'hc015;

endpackage

// File: rtl/key_channel.sv
// One push-button channel: synchronizer, debouncer, auto-repeat FSM and
// a sticky event flag cleared by a CPU read of CLR_ADDR.
module key_channel
  import key_event_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_RATE     = 5000000,
  parameter int unsigned REPEAT_EN       = 1,
  parameter logic [15:0] CLR_ADDR        = KEY_UP_ADDR
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        key_n,
  input  logic        mm_re,
  input  logic [15:0] addr,
  output logic        flag
);

  localparam int unsigned DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned TMR_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);
  localparam logic [TMR_W-1:0] TMR_SAT = '1;

  logic            sync_q1;
  logic            sync_q2;
  logic            stable_q;
  logic [DB_W-1:0] db_cnt_q;

  key_state_t       state_q;
  key_state_t       state_d;
  logic [TMR_W-1:0] tmr_q;
  logic [TMR_W-1:0] tmr_d;
  logic             event_c;
  logic             clr_c;

  // Two-flop synchronizer; resets to released so reset release is never a press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q1 <= 1'b1;
      sync_q2 <= 1'b1;
    end else begin
      sync_q1 <= key_n;
      sync_q2 <= sync_q1;
    end
  end

  // Debounce: accept a new level only after it has differed for DEBOUNCE_CYCLES in a row.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable_q <= 1'b1;
      db_cnt_q <= '0;
    end else if (sync_q2 != stable_q) begin
      if (db_cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
        stable_q <= sync_q2;
        db_cnt_q <= '0;
      end else begin
        db_cnt_q <= db_cnt_q + DB_W'(1);
      end
    end else begin
      db_cnt_q <= '0;
    end
  end

  // Event FSM state and repeat timer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      tmr_q   <= '0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
    end
  end

  // Next state: press event, first repeat after REPEAT_DELAY, then every REPEAT_RATE.
  always_comb begin
    state_d = state_q;
    tmr_d   = (tmr_q == TMR_SAT) ? tmr_q : tmr_q + TMR_W'(1);
    event_c = 1'b0;
    case (state_q)
      IDLE: begin
        tmr_d = '0;
        if (!stable_q) begin
          event_c = 1'b1;
          state_d = DELAY;
        end
      end
      DELAY: begin
        if (stable_q) begin
          state_d = IDLE;
          tmr_d   = '0;
        end else if ((REPEAT_EN != 0) && (tmr_q == TMR_W'(REPEAT_DELAY - 1))) begin
          event_c = 1'b1;
          tmr_d   = '0;
          state_d = REPEAT;
        end
      end
      REPEAT: begin
        if (stable_q) begin
          state_d = IDLE;
          tmr_d   = '0;
        end else if (tmr_q == TMR_W'(REPEAT_RATE - 1)) begin
          event_c = 1'b1;
          tmr_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        tmr_d   = '0;
      end
    endcase
  end

  assign clr_c = mm_re && (addr == CLR_ADDR);

  // Sticky flag: an event wins over a same-cycle read-clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag <= 1'b0;
    end else if (event_c) begin
      flag <= 1'b1;
    end else if (clr_c) begin
      flag <= 1'b0;
    end
  end

endmodule

// File: rtl/key_event_ctrl.sv
// Two independent button channels feeding the KEY_UP / KEY_DOWN register inputs.
module key_event_ctrl
  import key_event_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_RATE     = 5000000,
  parameter int unsigned REPEAT_EN       = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        key_up_n,
  input  logic        key_down_n,
  input  logic        mm_re,
  input  logic [15:0] addr,
  output logic        KEY_UP,
  output logic        KEY_DOWN
);

  key_channel #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .REPEAT_DELAY    (REPEAT_DELAY),
    .REPEAT_RATE     (REPEAT_RATE),
    .REPEAT_EN       (REPEAT_EN),
    .CLR_ADDR        (KEY_UP_ADDR)
  ) u_up (
    .clk   (clk),
    .rst_n (rst_n),
    .key_n (key_up_n),
    .mm_re (mm_re),
    .addr  (addr),
    .flag  (KEY_UP)
  );

  key_channel #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .REPEAT_DELAY    (REPEAT_DELAY),
    .REPEAT_RATE     (REPEAT_RATE),
    .REPEAT_EN       (REPEAT_EN),
    .CLR_ADDR        (KEY_DOWN_ADDR)
  ) u_down (
    .clk   (clk),
    .rst_n (rst_n),
    .key_n (key_down_n),
    .mm_re (mm_re),
    .addr  (addr),
    .flag  (KEY_DOWN)
  );

endmodule
